// File: rtl/ether_pkg.sv
// Shared types and helpers for the Ethernet pixel path.
package ether_pkg;

    typedef enum logic [1:0] {IDLE, HDR, PIX, SKIP} pw_state_t;

    localparam int unsigned HDR_DIBITS = 8;
    localparam int unsigned HDR_W      = 2 * HDR_DIBITS;

    // Add 0..3 to a 16-bit counter, clamping at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] sum;
        sum = 17'(v) + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/ether_pixel_writer_dibit_packer.sv
// Shifts 2-bit symbols MSB-first into a W-bit word; flags the dibit that completes it.
module dibit_packer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         shift_en,
    input  logic         flush,
    input  logic [1:0]   din,
    output logic [W-1:0] word_c,
    output logic         word_valid_c,
    output logic         pending_c
);

    localparam int unsigned N     = W / 2;
    localparam int unsigned CNT_W = $clog2(N + 1);

    logic [W-1:0]     sreg;
    logic [CNT_W-1:0] cnt;

    // Word as it would look with this cycle's dibit shifted in
    assign word_c       = W'({sreg, din});
    assign word_valid_c = shift_en && (cnt == CNT_W'(N - 1));
    assign pending_c    = (cnt != '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (flush) begin
            cnt  <= '0;
        end else if (shift_en) begin
            sreg <= word_c;
            cnt  <= word_valid_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ether_pixel_writer.sv
// Turns the filtered RMII dibit stream into frame-buffer write beats with wrapping addresses
// and keeps good/bad packet counters.
module ether_pixel_writer
    import ether_pkg::*;
#(
    parameter  int unsigned PIXEL_W   = 8,
    parameter  int unsigned FRAME_W   = 320,
    parameter  int unsigned FRAME_H   = 240,
    parameter  int unsigned ADDR_MODE = 0,
    localparam int unsigned ADDR_W    = $clog2(FRAME_W * FRAME_H)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               axiiv,
    input  logic [1:0]         axiid,
    input  logic               done_in,
    input  logic               kill_in,
    output logic               pixel_valid,
    output logic [ADDR_W-1:0]  pixel_addr,
    output logic [PIXEL_W-1:0] pixel_data,
    output logic               frame_done,
    output logic [15:0]        pkt_count,
    output logic [15:0]        err_count
);

    localparam int unsigned LAST_ADDR = FRAME_W * FRAME_H - 1;

    pw_state_t          state;
    logic               axiiv_q;
    logic [ADDR_W-1:0]  ptr;

    logic               sop_c;
    logic               pix_shift_c;
    logic               hdr_shift_c;
    logic [PIXEL_W-1:0] pix_word_c;
    logic               pix_valid_c;
    logic               pix_pending_c;
    logic [HDR_W-1:0]   hdr_word_c;
    logic               hdr_valid_c;
    logic               hdr_pending_c;
    logic               row_ok_c;
    logic               fsm_err_c;
    logic [1:0]         err_inc_c;
    logic               ptr_last_c;

    assign sop_c       = axiiv && !axiiv_q;
    assign pix_shift_c = axiiv && ((state == IDLE && sop_c && ADDR_MODE == 0) || state == PIX);
    assign hdr_shift_c = axiiv && ((state == IDLE && sop_c && ADDR_MODE != 0) || state == HDR);
    assign row_ok_c    = 32'(hdr_word_c) < FRAME_H;
    assign ptr_last_c  = (ptr == ADDR_W'(LAST_ADDR));

    // Truncated header, runt pixel at end of packet, or out-of-frame row
    assign fsm_err_c = (state == HDR && !axiiv)
                     || (state == PIX && !axiiv && pix_pending_c)
                     || (hdr_valid_c && !row_ok_c);
    assign err_inc_c = 2'(kill_in) + 2'(fsm_err_c);

    dibit_packer #(.W(PIXEL_W)) u_pix_packer (
        .clk          (clk),
        .rstn         (rstn),
        .shift_en     (pix_shift_c),
        .flush        (!axiiv),
        .din          (axiid),
        .word_c       (pix_word_c),
        .word_valid_c (pix_valid_c),
        .pending_c    (pix_pending_c)
    );

    dibit_packer #(.W(HDR_W)) u_hdr_packer (
        .clk          (clk),
        .rstn         (rstn),
        .shift_en     (hdr_shift_c),
        .flush        (!axiiv),
        .din          (axiid),
        .word_c       (hdr_word_c),
        .word_valid_c (hdr_valid_c),
        .pending_c    (hdr_pending_c)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            axiiv_q     <= 1'b1;
            ptr         <= '0;
            pixel_valid <= 1'b0;
            pixel_addr  <= '0;
            pixel_data  <= '0;
            frame_done  <= 1'b0;
            pkt_count   <= '0;
            err_count   <= '0;
        end else begin
            axiiv_q     <= axiiv;
            pixel_valid <= pix_valid_c;
            frame_done  <= pix_valid_c && ptr_last_c;

            if (pix_valid_c) begin
                pixel_addr <= ptr;
                pixel_data <= pix_word_c;
                ptr        <= ptr_last_c ? '0 : ptr + ADDR_W'(1);
            end else if (hdr_valid_c && row_ok_c) begin
                ptr <= ADDR_W'(ADDR_W'(hdr_word_c) * ADDR_W'(FRAME_W));
            end

            case (state)
                IDLE: if (sop_c) state <= (ADDR_MODE != 0) ? HDR : PIX;
                HDR: begin
                    if (!axiiv)           state <= IDLE;
                    else if (hdr_valid_c) state <= row_ok_c ? PIX : SKIP;
                end
                PIX:     if (!axiiv) state <= IDLE;
                SKIP:    if (!axiiv) state <= IDLE;
                default: state <= IDLE;
            endcase

            err_count <= sat_inc16(err_count, err_inc_c);
            if (done_in && !kill_in) pkt_count <= sat_inc16(pkt_count, 2'd1);
        end
    end

    // Header progress is tracked by the FSM; the pending flag is only needed for pixels
    logic unused_c;
    assign unused_c = hdr_pending_c;

endmodule

// File: tb/tb_ether_pixel_writer.sv
// Directed checks of ether_pixel_writer: packing, header placement, wrap, runts, counters, reset.
module tb_ether_pixel_writer;

    localparam int unsigned AW = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic          axiiv0, done0, kill0, pv0, fd0;
    logic [1:0]    axiid0;
    logic [AW-1:0] addr0;
    logic [7:0]    data0;
    logic [15:0]   pkt0, err0;

    logic          axiiv1, done1, kill1, pv1, fd1;
    logic [1:0]    axiid1;
    logic [AW-1:0] addr1;
    logic [7:0]    data1;
    logic [15:0]   pkt1, err1;

    int compared   = 0;
    int mismatched = 0;

    logic [AW-1:0] qa0[$];
    logic [7:0]    qd0[$];
    logic [AW-1:0] qa1[$];
    logic [7:0]    qd1[$];
    int            fd_cnt1;
    logic [AW-1:0] fd_addr1;

    ether_pixel_writer #(.PIXEL_W(8), .FRAME_W(320), .FRAME_H(240), .ADDR_MODE(0)) u0 (
        .clk(clk), .rstn(rstn), .axiiv(axiiv0), .axiid(axiid0), .done_in(done0), .kill_in(kill0),
        .pixel_valid(pv0), .pixel_addr(addr0), .pixel_data(data0), .frame_done(fd0),
        .pkt_count(pkt0), .err_count(err0)
    );

    ether_pixel_writer #(.PIXEL_W(8), .FRAME_W(320), .FRAME_H(240), .ADDR_MODE(1)) u1 (
        .clk(clk), .rstn(rstn), .axiiv(axiiv1), .axiid(axiid1), .done_in(done1), .kill_in(kill1),
        .pixel_valid(pv1), .pixel_addr(addr1), .pixel_data(data1), .frame_done(fd1),
        .pkt_count(pkt1), .err_count(err1)
    );

    // Write log per instance, sampled mid-cycle
    always @(negedge clk) begin
        if (pv0 === 1'b1) begin qa0.push_back(addr0); qd0.push_back(data0); end
        if (pv1 === 1'b1) begin qa1.push_back(addr1); qd1.push_back(data1); end
        if (fd1 === 1'b1) begin fd_cnt1++; fd_addr1 = addr1; end
    end

    function automatic logic [AW-1:0] a0_at(input int i);
        return (i < qa0.size()) ? qa0[i] : '1;
    endfunction
    function automatic logic [7:0] d0_at(input int i);
        return (i < qd0.size()) ? qd0[i] : 8'hxx;
    endfunction
    function automatic logic [AW-1:0] a1_at(input int i);
        return (i < qa1.size()) ? qa1[i] : '1;
    endfunction
    function automatic logic [7:0] d1_at(input int i);
        return (i < qd1.size()) ? qd1[i] : 8'hxx;
    endfunction

    task automatic tick0(input logic v, input logic [1:0] d);
        @(negedge clk); axiiv0 = v; axiid0 = d;
    endtask
    task automatic tick1(input logic v, input logic [1:0] d);
        @(negedge clk); axiiv1 = v; axiid1 = d;
    endtask
    task automatic idle0(input int n);
        for (int i = 0; i < n; i++) tick0(1'b0, 2'd0);
    endtask
    task automatic idle1(input int n);
        for (int i = 0; i < n; i++) tick1(1'b0, 2'd0);
    endtask
    task automatic send_byte0(input logic [7:0] b);
        for (int i = 0; i < 4; i++) tick0(1'b1, b[7-2*i -: 2]);
    endtask
    task automatic send_byte1(input logic [7:0] b);
        for (int i = 0; i < 4; i++) tick1(1'b1, b[7-2*i -: 2]);
    endtask
    task automatic send_hdr1(input logic [15:0] r);
        for (int i = 0; i < 8; i++) tick1(1'b1, r[15-2*i -: 2]);
    endtask
    task automatic clear_logs();
        qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
        fd_cnt1 = 0; fd_addr1 = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        axiiv0 = 0; axiid0 = 0; done0 = 0; kill0 = 0;
        axiiv1 = 0; axiid1 = 0; done1 = 0; kill1 = 0;
        repeat (3) @(negedge clk);
        compared++; if (pv0 !== 1'b0) begin mismatched++; $display("FAIL reset_pv: got %0d want 0", pv0); end
        compared++; if (addr0 !== '0) begin mismatched++; $display("FAIL reset_addr: got %0d want 0", addr0); end
        compared++; if (data0 !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %0h want 0", data0); end
        compared++; if (fd0 !== 1'b0) begin mismatched++; $display("FAIL reset_fd: got %0d want 0", fd0); end
        compared++; if (pkt0 !== 16'h0) begin mismatched++; $display("FAIL reset_pkt: got %0d want 0", pkt0); end
        compared++; if (err1 !== 16'h0) begin mismatched++; $display("FAIL reset_err: got %0d want 0", err1); end
        rstn = 1'b1;
        clear_logs();
    endtask

    task automatic test_basic_write();
        idle0(2);
        tick0(1'b1, 2'd3); tick0(1'b1, 2'd0); tick0(1'b1, 2'd2);
        @(negedge clk);
        compared++; if (pv0 !== 1'b0) begin mismatched++; $display("FAIL basic_early_pv: got %0d want 0", pv0); end
        axiiv0 = 1'b1; axiid0 = 2'd1;
        @(negedge clk);
        compared++; if (pv0 !== 1'b1) begin mismatched++; $display("FAIL basic_pv: got %0d want 1", pv0); end
        compared++; if (data0 !== 8'hC9) begin mismatched++; $display("FAIL basic_data: got %0h want c9", data0); end
        compared++; if (addr0 !== 17'd0) begin mismatched++; $display("FAIL basic_addr: got %0d want 0", addr0); end
        axiiv0 = 1'b0;
        @(negedge clk);
        compared++; if (pv0 !== 1'b0) begin mismatched++; $display("FAIL basic_pulse: got %0d want 0", pv0); end
        idle0(2);
    endtask

    task automatic test_runt();
        clear_logs();
        send_byte0(8'h6C);
        tick0(1'b1, 2'd3); tick0(1'b1, 2'd3);
        idle0(3);
        compared++; if (qa0.size() !== 1) begin mismatched++; $display("FAIL runt_writes: got %0d want 1", qa0.size()); end
        compared++; if (a0_at(0) !== 17'd1) begin mismatched++; $display("FAIL runt_addr: got %0d want 1", a0_at(0)); end
        compared++; if (d0_at(0) !== 8'h6C) begin mismatched++; $display("FAIL runt_data: got %0h want 6c", d0_at(0)); end
        compared++; if (err0 !== 16'd1) begin mismatched++; $display("FAIL runt_err: got %0d want 1", err0); end
        clear_logs();
        send_byte0(8'hAA);
        idle0(3);
        compared++; if (a0_at(0) !== 17'd2) begin mismatched++; $display("FAIL runt_next_addr: got %0d want 2", a0_at(0)); end
        compared++; if (d0_at(0) !== 8'hAA) begin mismatched++; $display("FAIL runt_next_data: got %0h want aa", d0_at(0)); end
        compared++; if (err0 !== 16'd1) begin mismatched++; $display("FAIL runt_next_err: got %0d want 1", err0); end
    endtask

    task automatic test_header();
        clear_logs();
        idle1(2);
        send_hdr1(16'd5);
        send_byte1(8'h12); send_byte1(8'h34);
        idle1(3);
        compared++; if (qa1.size() !== 2) begin mismatched++; $display("FAIL hdr_writes: got %0d want 2", qa1.size()); end
        compared++; if (a1_at(0) !== 17'd1600) begin mismatched++; $display("FAIL hdr_addr0: got %0d want 1600", a1_at(0)); end
        compared++; if (d1_at(0) !== 8'h12) begin mismatched++; $display("FAIL hdr_data0: got %0h want 12", d1_at(0)); end
        compared++; if (a1_at(1) !== 17'd1601) begin mismatched++; $display("FAIL hdr_addr1: got %0d want 1601", a1_at(1)); end
        compared++; if (d1_at(1) !== 8'h34) begin mismatched++; $display("FAIL hdr_data1: got %0h want 34", d1_at(1)); end
        compared++; if (err1 !== 16'd0) begin mismatched++; $display("FAIL hdr_err: got %0d want 0", err1); end
    endtask

    task automatic test_bad_header();
        clear_logs();
        send_hdr1(16'd240);
        send_byte1(8'hFF);
        idle1(3);
        compared++; if (qa1.size() !== 0) begin mismatched++; $display("FAIL badhdr_writes: got %0d want 0", qa1.size()); end
        compared++; if (err1 !== 16'd1) begin mismatched++; $display("FAIL badhdr_err: got %0d want 1", err1); end
        tick1(1'b1, 2'd0); tick1(1'b1, 2'd0); tick1(1'b1, 2'd1);
        idle1(3);
        compared++; if (err1 !== 16'd2) begin mismatched++; $display("FAIL shorthdr_err: got %0d want 2", err1); end
        compared++; if (qa1.size() !== 0) begin mismatched++; $display("FAIL shorthdr_writes: got %0d want 0", qa1.size()); end
    endtask

    task automatic test_wrap();
        clear_logs();
        send_hdr1(16'd239);
        for (int i = 0; i < 321; i++) send_byte1(8'(i));
        idle1(3);
        compared++; if (fd_cnt1 !== 1) begin mismatched++; $display("FAIL wrap_fd_count: got %0d want 1", fd_cnt1); end
        compared++; if (fd_addr1 !== 17'd76799) begin mismatched++; $display("FAIL wrap_fd_addr: got %0d want 76799", fd_addr1); end
        compared++; if (qa1.size() !== 321) begin mismatched++; $display("FAIL wrap_writes: got %0d want 321", qa1.size()); end
        compared++; if (a1_at(0) !== 17'd76480) begin mismatched++; $display("FAIL wrap_first: got %0d want 76480", a1_at(0)); end
        compared++; if (a1_at(320) !== 17'd0) begin mismatched++; $display("FAIL wrap_next: got %0d want 0", a1_at(320)); end
        compared++; if (d1_at(320) !== 8'h40) begin mismatched++; $display("FAIL wrap_next_data: got %0h want 40", d1_at(320)); end
    endtask

    task automatic test_counters();
        @(negedge clk); done0 = 1'b1;
        @(negedge clk); done0 = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (pkt0 !== 16'd1) begin mismatched++; $display("FAIL done_pkt: got %0d want 1", pkt0); end
        done0 = 1'b1; kill0 = 1'b1;
        @(negedge clk); done0 = 1'b0; kill0 = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (pkt0 !== 16'd1) begin mismatched++; $display("FAIL kill_pkt: got %0d want 1", pkt0); end
        compared++; if (err0 !== 16'd2) begin mismatched++; $display("FAIL kill_err: got %0d want 2", err0); end
        tick0(1'b1, 2'd2); tick0(1'b1, 2'd2);
        @(negedge clk); axiiv0 = 1'b0; kill0 = 1'b1;
        @(negedge clk); kill0 = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (err0 !== 16'd4) begin mismatched++; $display("FAIL kill_runt_err: got %0d want 4", err0); end
    endtask

    task automatic test_saturation();
        @(negedge clk); done0 = 1'b1; kill1 = 1'b1;
        repeat (65540) @(negedge clk);
        done0 = 1'b0; kill1 = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (pkt0 !== 16'hFFFF) begin mismatched++; $display("FAIL sat_pkt: got %0h want ffff", pkt0); end
        compared++; if (err1 !== 16'hFFFF) begin mismatched++; $display("FAIL sat_err: got %0h want ffff", err1); end
        compared++; if (err0 !== 16'd4) begin mismatched++; $display("FAIL sat_err_other: got %0d want 4", err0); end
        tick1(1'b1, 2'd0); tick1(1'b1, 2'd0);
        @(negedge clk); axiiv1 = 1'b0; kill1 = 1'b1;
        @(negedge clk); kill1 = 1'b0; done0 = 1'b1;
        @(negedge clk); done0 = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (err1 !== 16'hFFFF) begin mismatched++; $display("FAIL sat_err_plus2: got %0h want ffff", err1); end
        compared++; if (pkt0 !== 16'hFFFF) begin mismatched++; $display("FAIL sat_pkt_hold: got %0h want ffff", pkt0); end
    endtask

    task automatic test_reset_mid_packet();
        idle0(2);
        clear_logs();
        tick0(1'b1, 2'd1); tick0(1'b1, 2'd2);
        @(negedge clk); rstn = 1'b0; axiid0 = 2'd3;
        repeat (2) @(negedge clk);
        compared++; if (pv0 !== 1'b0) begin mismatched++; $display("FAIL midrst_pv: got %0d want 0", pv0); end
        compared++; if (addr0 !== '0) begin mismatched++; $display("FAIL midrst_addr: got %0d want 0", addr0); end
        compared++; if (data0 !== 8'h00) begin mismatched++; $display("FAIL midrst_data: got %0h want 0", data0); end
        compared++; if (pkt0 !== 16'd0) begin mismatched++; $display("FAIL midrst_pkt: got %0d want 0", pkt0); end
        compared++; if (err0 !== 16'd0) begin mismatched++; $display("FAIL midrst_err: got %0d want 0", err0); end
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) tick0(1'b1, 2'd1);
        tick0(1'b1, 2'd1);
        compared++; if (qa0.size() !== 0) begin mismatched++; $display("FAIL midrst_ignored: got %0d want 0", qa0.size()); end
        idle0(2);
        send_byte0(8'h3C);
        idle0(3);
        compared++; if (qa0.size() !== 1) begin mismatched++; $display("FAIL midrst_writes: got %0d want 1", qa0.size()); end
        compared++; if (a0_at(0) !== 17'd0) begin mismatched++; $display("FAIL midrst_addr2: got %0d want 0", a0_at(0)); end
        compared++; if (d0_at(0) !== 8'h3C) begin mismatched++; $display("FAIL midrst_data2: got %0h want 3c", d0_at(0)); end
        compared++; if (err0 !== 16'd0) begin mismatched++; $display("FAIL midrst_err2: got %0d want 0", err0); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_runt();
        test_header();
        test_bad_header();
        test_wrap();
        test_counters();
        test_saturation();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
